// File: rtl/uart_tx_frame_if.sv
// Byte handoff between an upstream producer and uart_tx_frame (valid/ready).
interface uart_tx_frame_if #(
  parameter int unsigned PAYLOAD_BITS = 8
) ();
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, optional parity, stop bit(s).
// Bytes arrive over a valid/ready handshake; the serial line is driven straight from a flop.
module uart_tx_frame #(
  parameter int unsigned BIT_RATE     = 11520,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY       = 0
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_frame_if.slave   tx_if,
  output logic             tx_busy,
  output logic             uart_txd
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int unsigned CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int unsigned BIT_W          = 4;

  if (CYCLES_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLK_HZ / BIT_RATE must be at least 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_payload
    $error("uart_tx_frame: PAYLOAD_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    txd_q, txd_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    bit_end;

  // State and output registers; reset parks the line high and abandons any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; the line level for each bit is registered on the edge that starts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    bit_end = (cnt_q == CNT_W'(CYCLES_PER_BIT - 1));

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
        if (tx_if.tx_valid && ready_q) begin
          state_d = ST_START;
          shift_d = tx_if.tx_data;
          par_d   = (PARITY == 1) ? ~(^tx_if.tx_data) : (^tx_if.tx_data);
          txd_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(PAYLOAD_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_busy        = busy_q;
  assign uart_txd       = txd_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at 8 clocks per bit: framing, parity, stop bits,
// back-to-back transfers, reset mid-frame and busy-time handshake abuse.
module tb_uart_tx_frame;

  localparam int unsigned CLK_HZ   = 1000000;
  localparam int unsigned BIT_RATE = 125000;
  localparam int          CPB      = 8;

  logic       clk;
  logic       reset;
  logic [7:0] data [4];
  logic [3:0] valid;
  wire  [3:0] txd;
  wire  [3:0] busy;
  wire  [3:0] ready;
  logic [7:0] msg  [4];

  int n_checks;
  int n_errors;
  int cyc;

  uart_tx_frame_if #(.PAYLOAD_BITS(8)) if_n ();
  uart_tx_frame_if #(.PAYLOAD_BITS(8)) if_e ();
  uart_tx_frame_if #(.PAYLOAD_BITS(8)) if_o ();
  uart_tx_frame_if #(.PAYLOAD_BITS(8)) if_s ();

  assign if_n.tx_data = data[0];  assign if_n.tx_valid = valid[0];  assign ready[0] = if_n.tx_ready;
  assign if_e.tx_data = data[1];  assign if_e.tx_valid = valid[1];  assign ready[1] = if_e.tx_ready;
  assign if_o.tx_data = data[2];  assign if_o.tx_valid = valid[2];  assign ready[2] = if_o.tx_ready;
  assign if_s.tx_data = data[3];  assign if_s.tx_valid = valid[3];  assign ready[3] = if_s.tx_ready;

  uart_tx_frame #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(0))
    u_none (.clk(clk), .reset(reset), .tx_if(if_n), .tx_busy(busy[0]), .uart_txd(txd[0]));
  uart_tx_frame #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(2))
    u_even (.clk(clk), .reset(reset), .tx_if(if_e), .tx_busy(busy[1]), .uart_txd(txd[1]));
  uart_tx_frame #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(1))
    u_odd  (.clk(clk), .reset(reset), .tx_if(if_o), .tx_busy(busy[2]), .uart_txd(txd[2]));
  uart_tx_frame #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(2), .PARITY(0))
    u_stop2 (.clk(clk), .reset(reset), .tx_if(if_s), .tx_busy(busy[3]), .uart_txd(txd[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    while (ready[u] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready[u]), 32'd1);
  endtask

  // Hand a byte over at a negedge; the following posedge accepts it.
  task automatic send(input int u, input logic [7:0] b, input bit hold);
    wait_ready(u);
    data[u]  = b;
    valid[u] = 1'b1;
    @(negedge clk);
    if (!hold) valid[u] = 1'b0;
  endtask

  // Samples the line every cycle of nbits bit periods; optionally pokes the handshake mid-frame.
  task automatic capture(input int u, input int nbits, input int poke,
                         output logic [15:0] bits, output int bad,
                         output int rdy_hi, output int busy_lo);
    bits    = '0;
    bad     = 0;
    rdy_hi  = 0;
    busy_lo = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        int k;
        k = b * CPB + c;
        if (c == 0) bits[b] = txd[u];
        else if (txd[u] !== bits[b]) bad++;
        if (ready[u] !== 1'b0) rdy_hi++;
        if (busy[u] !== 1'b1) busy_lo++;
        if (poke >= 0 && k == poke) begin
          data[u]  = 8'hAA;
          valid[u] = 1'b1;
        end
        if (poke >= 0 && k == poke + 1) valid[u] = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_frame(input string tag, input int u, input int nbits, input int poke,
                             input logic [15:0] exp);
    logic [15:0] bits;
    int bad, rdy_hi, busy_lo;
    capture(u, nbits, poke, bits, bad, rdy_hi, busy_lo);
    check({tag, "_bits"},    32'(bits),     32'(exp));
    check({tag, "_stable"},  32'(bad),      32'd0);
    check({tag, "_rdy_low"}, 32'(rdy_hi),   32'd0);
    check({tag, "_busy"},    32'(busy_lo),  32'd0);
    check({tag, "_end_rdy"}, 32'(ready[u]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int bad, rdy_hi, busy_lo, t_prev, t_now, lows, rdy_lows;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    reset    = 1'b1;
    valid    = '0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    msg[0] = 8'h41; msg[1] = 8'h31; msg[2] = 8'h42; msg[3] = 8'h32;

    // Reset values, then tx_ready one edge after release
    repeat (2) @(negedge clk);
    check("rst_txd",   32'(txd[0]),   32'd1);
    check("rst_ready", 32'(ready[0]), 32'd0);
    check("rst_busy",  32'(busy[0]),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'hF);

    // 8'h41, single-cycle valid: 0,1,0,0,0,0,0,1,0,1
    send(0, 8'h41, 1'b0);
    check_frame("t1", 0, 10, -1, 16'h0282);

    // "A1B2" with tx_valid held: contiguous frames, starts 10*CPB+1 cycles apart
    wait_ready(0);
    data[0]  = msg[0];
    valid[0] = 1'b1;
    @(negedge clk);
    t_prev = cyc;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) data[0] = msg[k + 1];
      else valid[0] = 1'b0;
      capture(0, 10, -1, bits, bad, rdy_hi, busy_lo);
      check("t2_byte",   32'(bits[8:1]),          32'(msg[k]));
      check("t2_frame",  32'({bits[9], bits[0]}), 32'd2);
      check("t2_stable", 32'(bad + rdy_hi),       32'd0);
      check("t2_rdy",    32'(ready[0]),           32'd1);
      if (k < 3) begin
        @(negedge clk);
        t_now = cyc;
        check("t2_gap", 32'(t_now - t_prev), 32'(10 * CPB + 1));
        t_prev = t_now;
      end
    end

    // Parity: 8'h07 even -> 1, odd -> 0; eleven bit periods
    send(1, 8'h07, 1'b0);
    check_frame("t3_even", 1, 11, -1, 16'h060E);
    send(2, 8'h07, 1'b0);
    check_frame("t3_odd", 2, 11, -1, 16'h040E);

    // Two stop bits: 9 low periods then 2 high periods before tx_ready
    send(3, 8'h00, 1'b0);
    check_frame("t4", 3, 11, -1, 16'h0600);

    // Reset during the start bit forces the line high at once
    send(0, 8'hFF, 1'b0);
    @(negedge clk);
    check("t5a_start_low", 32'(txd[0]), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("t5a_txd_forced", 32'(txd[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Reset three bit periods into 8'hFF: frame abandoned, then a clean 8'h55
    send(0, 8'hFF, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t5_txd",  32'(txd[0]),  32'd1);
    check("t5_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    check("t5_abandoned", 32'(lows), 32'd0);
    send(0, 8'h55, 1'b0);
    check_frame("t5_clean", 0, 10, -1, 16'h02AA);

    // tx_data changed and tx_valid pulsed mid-frame: only 8'h0F goes out
    send(0, 8'h0F, 1'b0);
    check_frame("t6", 0, 10, 3 * CPB, 16'h021E);
    lows     = 0;
    rdy_lows = 0;
    for (int i = 0; i < 3 * 10 * CPB; i++) begin
      if (txd[0] !== 1'b1) lows++;
      if (ready[0] !== 1'b1) rdy_lows++;
      @(negedge clk);
    end
    check("t6_no_second_frame", 32'(lows),     32'd0);
    check("t6_stays_ready",     32'(rdy_lows), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
